// File: rtl/tlb_op_seq_pkg.sv
// -----------------------------------------------------------------------------
// tlb_op_seq_pkg
// Shared definitions for the TLB-maintenance sequencer (the cpuDefine set):
// TLB geometry, the TlbOp encoding presented by writeback, the INVTLB op
// field constants and the sequencer state encoding.
// -----------------------------------------------------------------------------
package tlb_op_seq_pkg;

    localparam int TLBNUM     = 16;
    localparam int TLBNUMSIZE = 4;

    typedef enum logic [2:0] {
        TLBOP_SRCH = 3'd0,
        TLBOP_RD   = 3'd1,
        TLBOP_WR   = 3'd2,
        TLBOP_FILL = 3'd3,
        TLBOP_INV  = 3'd4
    } tlb_op_e;

    // INVTLB op field values
    localparam logic [4:0] INVTLB_ALL0         = 5'd0;
    localparam logic [4:0] INVTLB_ALL1         = 5'd1;
    localparam logic [4:0] INVTLB_G1           = 5'd2;
    localparam logic [4:0] INVTLB_G0           = 5'd3;
    localparam logic [4:0] INVTLB_G0_ASID      = 5'd4;
    localparam logic [4:0] INVTLB_G0_ASID_VA   = 5'd5;
    localparam logic [4:0] INVTLB_GASID_VA     = 5'd6;
    localparam logic [4:0] INVTLB_OP_MAX       = 5'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SRCH,
        ST_SRCH_WB,
        ST_RD,
        ST_RD_WB,
        ST_WR,
        ST_INV_WALK,
        ST_DONE
    } state_e;

endpackage

// File: rtl/tlb_op_seq_inv_match.sv
// -----------------------------------------------------------------------------
// tlb_inv_match
// Combinational INVTLB match predicate for one TLB entry.
// Ports:
//   inv_op_i, inv_asid_i, inv_va_i   : INVTLB operands
//   entry_g_i, entry_asid_i,
//   entry_vppn_i, entry_ps_i         : fields of the entry under test
//   match_o                          : entry selected by this INVTLB op
// The entry valid bit is not considered here; the caller qualifies with E.
// -----------------------------------------------------------------------------
module tlb_inv_match
    import tlb_op_seq_pkg::*;
(
    input  logic [4:0]  inv_op_i,
    input  logic [9:0]  inv_asid_i,
    input  logic [31:0] inv_va_i,
    input  logic        entry_g_i,
    input  logic [9:0]  entry_asid_i,
    input  logic [18:0] entry_vppn_i,
    input  logic [5:0]  entry_ps_i,
    output logic        match_o
);

    logic asid_eq;
    logic va_eq;
    logic unused_va_low;

    // Page offset bits never take part in the VA compare.
    assign unused_va_low = ^inv_va_i[12:0];

    assign asid_eq = (entry_asid_i == inv_asid_i);
    // 4 MB pages (ps == 21) ignore the low 9 VPPN bits.
    assign va_eq   = (entry_vppn_i[18:9] == inv_va_i[31:22]) &&
                     ((entry_ps_i == 6'd21) || (entry_vppn_i[8:0] == inv_va_i[21:13]));

    always_comb begin
        match_o = 1'b0;
        case (inv_op_i)
            INVTLB_ALL0,
            INVTLB_ALL1:       match_o = 1'b1;
            INVTLB_G1:         match_o = entry_g_i;
            INVTLB_G0:         match_o = ~entry_g_i;
            INVTLB_G0_ASID:    match_o = ~entry_g_i & asid_eq;
            INVTLB_G0_ASID_VA: match_o = ~entry_g_i & asid_eq & va_eq;
            INVTLB_GASID_VA:   match_o = (entry_g_i | asid_eq) & va_eq;
            default:           match_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/tlb_op_seq.sv
// -----------------------------------------------------------------------------
// tlb_op_seq
// Writeback-stage sequencer for TLBSRCH / TLBRD / TLBWR / TLBFILL / INVTLB.
// Accepts one op when idle, drives the TLB search/read/write/invalidate ports
// in a fixed order, emits the CSR strobes (s1e, re) and a done pulse with a
// pc+4 refetch request (or ine_exc for an illegal INVTLB op). busy stalls WB.
// Ports:
//   clk, resetn (async, active low)
//   op_valid/op_type/inv_op/inv_asid/inv_va : op from WB; op_ready, busy
//   csr_asid/csr_vppn/csr_index             : CSR operands
//   s1_*                                    : search port and CSR writeback
//   r_index/re, we/w_index                  : read / write ports
//   inv_rd_index, inv_entry_*, inv_clr*     : invalidate walk
//   done, refetch, ine_exc                  : completion
// Build option: define TLB_FILL_LFSR_EN to pick the TLBFILL index from a
// 16-bit LFSR instead of the default free-running up-counter.
// -----------------------------------------------------------------------------
module tlb_op_seq
    import tlb_op_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  op_valid,
    input  logic [2:0]            op_type,
    input  logic [4:0]            inv_op,
    input  logic [9:0]            inv_asid,
    input  logic [31:0]           inv_va,
    output logic                  op_ready,
    output logic                  busy,
    input  logic [9:0]            csr_asid,
    input  logic [18:0]           csr_vppn,
    input  logic [TLBNUMSIZE-1:0] csr_index,
    output logic                  s1_req,
    output logic [18:0]           s1_vppn,
    output logic [9:0]            s1_asid,
    input  logic                  s1_found,
    input  logic [TLBNUMSIZE-1:0] s1_hit_index,
    output logic                  s1e,
    output logic [TLBNUMSIZE-1:0] s1_index,
    output logic                  s1_ne,
    output logic [TLBNUMSIZE-1:0] r_index,
    output logic                  re,
    output logic                  we,
    output logic [TLBNUMSIZE-1:0] w_index,
    output logic [TLBNUMSIZE-1:0] inv_rd_index,
    input  logic                  inv_entry_e,
    input  logic                  inv_entry_g,
    input  logic [9:0]            inv_entry_asid,
    input  logic [18:0]           inv_entry_vppn,
    input  logic [5:0]            inv_entry_ps,
    output logic                  inv_clr,
    output logic [TLBNUMSIZE-1:0] inv_clr_index,
    output logic                  done,
    output logic                  refetch,
    output logic                  ine_exc
);

    state_e                  state_q, state_d;
    logic [TLBNUMSIZE-1:0]   i_q, i_d;
    logic [TLBNUMSIZE-1:0]   idx_q, idx_d;
    logic [4:0]              inv_op_q, inv_op_d;
    logic [9:0]              inv_asid_q, inv_asid_d;
    logic [31:0]             inv_va_q, inv_va_d;
    logic                    ine_q, ine_d;
    logic [18:0]             s1_vppn_q, s1_vppn_d;
    logic [9:0]              s1_asid_q, s1_asid_d;
    // Holds op_ready low while reset is asserted so every output reads 0.
    logic                    run_q;
    logic [TLBNUMSIZE-1:0]   fill_idx;
    logic                    match;

`ifdef TLB_FILL_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11
    assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign fill_idx = lfsr_q[TLBNUMSIZE-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_q <= 16'hACE1;
        else         lfsr_q <= lfsr_d;
    end
`else
    logic [TLBNUMSIZE-1:0] fill_q, fill_d;

    assign fill_d   = fill_q + 1'b1;
    assign fill_idx = fill_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) fill_q <= '0;
        else         fill_q <= fill_d;
    end
`endif

    tlb_inv_match u_match (
        .inv_op_i     (inv_op_q),
        .inv_asid_i   (inv_asid_q),
        .inv_va_i     (inv_va_q),
        .entry_g_i    (inv_entry_g),
        .entry_asid_i (inv_entry_asid),
        .entry_vppn_i (inv_entry_vppn),
        .entry_ps_i   (inv_entry_ps),
        .match_o      (match)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            run_q      <= 1'b0;
            i_q        <= '0;
            idx_q      <= '0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_va_q   <= '0;
            ine_q      <= 1'b0;
            s1_vppn_q  <= '0;
            s1_asid_q  <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            i_q        <= i_d;
            idx_q      <= idx_d;
            inv_op_q   <= inv_op_d;
            inv_asid_q <= inv_asid_d;
            inv_va_q   <= inv_va_d;
            ine_q      <= ine_d;
            s1_vppn_q  <= s1_vppn_d;
            s1_asid_q  <= s1_asid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        idx_d      = idx_q;
        inv_op_d   = inv_op_q;
        inv_asid_d = inv_asid_q;
        inv_va_d   = inv_va_q;
        ine_d      = ine_q;
        s1_vppn_d  = s1_vppn_q;
        s1_asid_d  = s1_asid_q;
        case (state_q)
            ST_IDLE: begin
                if (op_valid && op_ready) begin
                    ine_d = 1'b0;
                    case (op_type)
                        TLBOP_SRCH: begin
                            state_d   = ST_SRCH;
                            s1_vppn_d = csr_vppn;
                            s1_asid_d = csr_asid;
                        end
                        TLBOP_RD: begin
                            state_d = ST_RD;
                            idx_d   = csr_index;
                        end
                        TLBOP_WR: begin
                            state_d = ST_WR;
                            idx_d   = csr_index;
                        end
                        TLBOP_FILL: begin
                            state_d = ST_WR;
                            idx_d   = fill_idx;
                        end
                        TLBOP_INV: begin
                            inv_op_d   = inv_op;
                            inv_asid_d = inv_asid;
                            inv_va_d   = inv_va;
                            i_d        = '0;
                            if (inv_op > INVTLB_OP_MAX) begin
                                state_d = ST_DONE;
                                ine_d   = 1'b1;
                            end else begin
                                state_d = ST_INV_WALK;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_SRCH:    state_d = ST_SRCH_WB;
            ST_SRCH_WB: state_d = ST_DONE;
            ST_RD:      state_d = ST_RD_WB;
            ST_RD_WB:   state_d = ST_DONE;
            ST_WR:      state_d = ST_DONE;
            ST_INV_WALK: begin
                i_d = i_q + 1'b1;
                if (i_q == TLBNUMSIZE'(TLBNUM - 1)) state_d = ST_DONE;
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // All strobes decode from the registered state only.
    always_comb begin
        op_ready      = (state_q == ST_IDLE) && run_q;
        busy          = (state_q != ST_IDLE);
        s1_req        = (state_q == ST_SRCH);
        s1e           = (state_q == ST_SRCH_WB);
        s1_index      = s1e ? s1_hit_index : '0;
        s1_ne         = s1e & ~s1_found;
        re            = (state_q == ST_RD_WB);
        r_index       = ((state_q == ST_RD) || re) ? idx_q : '0;
        we            = (state_q == ST_WR);
        w_index       = we ? idx_q : '0;
        inv_rd_index  = (state_q == ST_INV_WALK) ? i_q : '0;
        inv_clr       = (state_q == ST_INV_WALK) & match & inv_entry_e;
        inv_clr_index = inv_rd_index;
        done          = (state_q == ST_DONE);
        refetch       = done & ~ine_q;
        ine_exc       = done & ine_q;
    end

    assign s1_vppn = s1_vppn_q;
    assign s1_asid = s1_asid_q;

endmodule

// File: tb/tb_tlb_op_seq.sv
module tb_tlb_op_seq;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        op_valid;
    logic [2:0]  op_type;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [31:0] inv_va;
    logic        op_ready, busy;
    logic [9:0]  csr_asid;
    logic [18:0] csr_vppn;
    logic [3:0]  csr_index;
    logic        s1_req;
    logic [18:0] s1_vppn;
    logic [9:0]  s1_asid;
    logic        s1_found;
    logic [3:0]  s1_hit_index;
    logic        s1e;
    logic [3:0]  s1_index;
    logic        s1_ne;
    logic [3:0]  r_index;
    logic        re, we;
    logic [3:0]  w_index;
    logic [3:0]  inv_rd_index;
    logic        inv_entry_e, inv_entry_g;
    logic [9:0]  inv_entry_asid;
    logic [18:0] inv_entry_vppn;
    logic [5:0]  inv_entry_ps;
    logic        inv_clr;
    logic [3:0]  inv_clr_index;
    logic        done, refetch, ine_exc;

    tlb_op_seq dut (
        .clk(clk), .resetn(resetn),
        .op_valid(op_valid), .op_type(op_type), .inv_op(inv_op),
        .inv_asid(inv_asid), .inv_va(inv_va),
        .op_ready(op_ready), .busy(busy),
        .csr_asid(csr_asid), .csr_vppn(csr_vppn), .csr_index(csr_index),
        .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_hit_index(s1_hit_index),
        .s1e(s1e), .s1_index(s1_index), .s1_ne(s1_ne),
        .r_index(r_index), .re(re), .we(we), .w_index(w_index),
        .inv_rd_index(inv_rd_index),
        .inv_entry_e(inv_entry_e), .inv_entry_g(inv_entry_g),
        .inv_entry_asid(inv_entry_asid), .inv_entry_vppn(inv_entry_vppn),
        .inv_entry_ps(inv_entry_ps),
        .inv_clr(inv_clr), .inv_clr_index(inv_clr_index),
        .done(done), .refetch(refetch), .ine_exc(ine_exc)
    );

    always #5 clk = ~clk;

    // Small TLB image seen by the invalidate walk
    logic        ent_e    [16];
    logic        ent_g    [16];
    logic [9:0]  ent_asid [16];
    logic [18:0] ent_vppn [16];
    logic [5:0]  ent_ps   [16];

    assign inv_entry_e    = ent_e[inv_rd_index];
    assign inv_entry_g    = ent_g[inv_rd_index];
    assign inv_entry_asid = ent_asid[inv_rd_index];
    assign inv_entry_vppn = ent_vppn[inv_rd_index];
    assign inv_entry_ps   = ent_ps[inv_rd_index];

    // Reference fill counter: counts every clock out of reset
    logic [3:0] model_fill;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) model_fill <= 4'd0;
        else         model_fill <= model_fill + 4'd1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  iop;
        logic [3:0]  cidx;
        logic        found;
        logic [3:0]  hit;
        logic [9:0]  asid;
        logic [31:0] va;
        logic [18:0] vppn;
        int          lat;
        logic [15:0] mask;
        logic        ine;
    } vec_t;

    vec_t vecs[14];

    task automatic run_vec(input int n, input vec_t v);
        logic [3:0] exp_w;
        logic       is_srch, is_rd, is_wr, is_walk, exp_clr;
        op_type      = v.op;
        inv_op       = v.iop;
        inv_asid     = v.asid;
        inv_va       = v.va;
        csr_index    = v.cidx;
        csr_vppn     = v.vppn;
        csr_asid     = v.asid;
        s1_found     = v.found;
        s1_hit_index = v.hit;
        is_srch = (v.op == 3'd0);
        is_rd   = (v.op == 3'd1);
        is_wr   = (v.op == 3'd2) || (v.op == 3'd3);
        is_walk = (v.op == 3'd4) && !v.ine;
        exp_w   = (v.op == 3'd3) ? model_fill : v.cidx;
        chk($sformatf("v%0d ready_at_accept", n), 32'(op_ready), 32'd1);
        op_valid = 1'b1;
        cyc();
        op_valid = 1'b0;
        for (int k = 1; k <= v.lat; k++) begin
            chk($sformatf("v%0d k%0d busy", n, k), 32'(busy), 32'd1);
            chk($sformatf("v%0d k%0d op_ready", n, k), 32'(op_ready), 32'd0);
            chk($sformatf("v%0d k%0d s1_req", n, k), 32'(s1_req), 32'(is_srch && k == 1));
            if (is_srch && k == 1) begin
                chk($sformatf("v%0d s1_vppn", n), 32'(s1_vppn), 32'(v.vppn));
                chk($sformatf("v%0d s1_asid", n), 32'(s1_asid), 32'(v.asid));
            end
            chk($sformatf("v%0d k%0d s1e", n, k), 32'(s1e), 32'(is_srch && k == 2));
            chk($sformatf("v%0d k%0d s1_index", n, k), 32'(s1_index),
                (is_srch && k == 2) ? 32'(v.hit) : 32'd0);
            chk($sformatf("v%0d k%0d s1_ne", n, k), 32'(s1_ne), 32'(is_srch && k == 2 && !v.found));
            chk($sformatf("v%0d k%0d re", n, k), 32'(re), 32'(is_rd && k == 2));
            chk($sformatf("v%0d k%0d r_index", n, k), 32'(r_index),
                (is_rd && k <= 2) ? 32'(v.cidx) : 32'd0);
            chk($sformatf("v%0d k%0d we", n, k), 32'(we), 32'(is_wr && k == 1));
            if (is_wr && k == 1)
                chk($sformatf("v%0d w_index", n), 32'(w_index), 32'(exp_w));
            if (is_walk && k <= 16) begin
                exp_clr = v.mask[k-1];
                chk($sformatf("v%0d k%0d inv_rd_index", n, k), 32'(inv_rd_index), 32'(k - 1));
                if (exp_clr)
                    chk($sformatf("v%0d k%0d inv_clr_index", n, k), 32'(inv_clr_index), 32'(k - 1));
            end else begin
                exp_clr = 1'b0;
            end
            chk($sformatf("v%0d k%0d inv_clr", n, k), 32'(inv_clr), 32'(exp_clr));
            chk($sformatf("v%0d k%0d done", n, k), 32'(done), 32'(k == v.lat));
            chk($sformatf("v%0d k%0d refetch", n, k), 32'(refetch), 32'(k == v.lat && !v.ine));
            chk($sformatf("v%0d k%0d ine_exc", n, k), 32'(ine_exc), 32'(k == v.lat && v.ine));
            if (k != v.lat) cyc();
        end
        cyc();
        chk($sformatf("v%0d ready_after_done", n), 32'(op_ready), 32'd1);
        chk($sformatf("v%0d done_single", n), 32'(done), 32'd0);
    endtask

    initial begin
        for (int j = 0; j < 16; j++) begin
            ent_e[j] = 1'b0; ent_g[j] = 1'b0; ent_asid[j] = 10'd0;
            ent_vppn[j] = 19'd0; ent_ps[j] = 6'd12;
        end
        // va 32'h0040_2000 -> vppn 19'h201 (hi 10 bits = 1, lo 9 bits = 1)
        ent_e[2]  = 1; ent_g[2]  = 0; ent_asid[2]  = 10'd7; ent_vppn[2]  = 19'h201; ent_ps[2]  = 6'd12;
        ent_e[4]  = 1; ent_g[4]  = 1; ent_asid[4]  = 10'd7; ent_vppn[4]  = 19'h201; ent_ps[4]  = 6'd12;
        ent_e[6]  = 1; ent_g[6]  = 0; ent_asid[6]  = 10'd7; ent_vppn[6]  = 19'h3FF; ent_ps[6]  = 6'd21;
        ent_e[8]  = 1; ent_g[8]  = 0; ent_asid[8]  = 10'd8; ent_vppn[8]  = 19'h201; ent_ps[8]  = 6'd12;
        ent_e[10] = 0; ent_g[10] = 0; ent_asid[10] = 10'd7; ent_vppn[10] = 19'h201; ent_ps[10] = 6'd12;
        ent_e[12] = 1; ent_g[12] = 0; ent_asid[12] = 10'd7; ent_vppn[12] = 19'h3FF; ent_ps[12] = 6'd12;

        //            op    iop   cidx  fnd   hit   asid    va             vppn       lat mask      ine
        vecs[0]  = '{3'd0, 5'd0, 4'd0, 1'b1, 4'd5, 10'd3, 32'h0,         19'h1234,  3, 16'h0000, 1'b0};
        vecs[1]  = '{3'd0, 5'd0, 4'd0, 1'b0, 4'd11,10'd9, 32'h0,         19'h7ABCD, 3, 16'h0000, 1'b0};
        vecs[2]  = '{3'd1, 5'd0, 4'd9, 1'b0, 4'd0, 10'd0, 32'h0,         19'h0,     3, 16'h0000, 1'b0};
        vecs[3]  = '{3'd3, 5'd0, 4'd3, 1'b0, 4'd0, 10'd0, 32'h0,         19'h0,     2, 16'h0000, 1'b0};
        vecs[4]  = '{3'd3, 5'd0, 4'd3, 1'b0, 4'd0, 10'd0, 32'h0,         19'h0,     2, 16'h0000, 1'b0};
        vecs[5]  = '{3'd3, 5'd0, 4'd3, 1'b0, 4'd0, 10'd0, 32'h0,         19'h0,     2, 16'h0000, 1'b0};
        vecs[6]  = '{3'd2, 5'd0, 4'd3, 1'b0, 4'd0, 10'd0, 32'h0,         19'h0,     2, 16'h0000, 1'b0};
        vecs[7]  = '{3'd4, 5'd5, 4'd0, 1'b0, 4'd0, 10'd7, 32'h0040_2000, 19'h0,    17, 16'h0044, 1'b0};
        vecs[8]  = '{3'd4, 5'd2, 4'd0, 1'b0, 4'd0, 10'd7, 32'h0040_2000, 19'h0,    17, 16'h0010, 1'b0};
        vecs[9]  = '{3'd4, 5'd4, 4'd0, 1'b0, 4'd0, 10'd7, 32'h0040_2000, 19'h0,    17, 16'h1044, 1'b0};
        vecs[10] = '{3'd4, 5'd6, 4'd0, 1'b0, 4'd0, 10'd7, 32'h0040_2000, 19'h0,    17, 16'h0054, 1'b0};
        vecs[11] = '{3'd4, 5'd0, 4'd0, 1'b0, 4'd0, 10'd7, 32'h0040_2000, 19'h0,    17, 16'h1154, 1'b0};
        vecs[12] = '{3'd4, 5'd9, 4'd0, 1'b0, 4'd0, 10'd7, 32'h0040_2000, 19'h0,     1, 16'h0000, 1'b1};
        vecs[13] = '{3'd4, 5'd3, 4'd0, 1'b0, 4'd0, 10'd7, 32'h0040_2000, 19'h0,    17, 16'h1144, 1'b0};

        op_valid = 0; op_type = 0; inv_op = 0; inv_asid = 0; inv_va = 0;
        csr_asid = 0; csr_vppn = 0; csr_index = 0; s1_found = 0; s1_hit_index = 0;

        // Reset state
        resetn = 1'b0;
        cyc(); cyc();
        chk("rst op_ready", 32'(op_ready), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst s1_vppn", 32'(s1_vppn), 32'd0);
        chk("rst inv_rd_index", 32'(inv_rd_index), 32'd0);
        resetn = 1'b1;
        cyc();
        chk("post_rst op_ready", 32'(op_ready), 32'd1);

        // Unsupported op type is ignored
        op_type = 3'd5; op_valid = 1'b1;
        cyc();
        op_valid = 1'b0;
        chk("bad_type busy", 32'(busy), 32'd0);
        chk("bad_type op_ready", 32'(op_ready), 32'd1);
        cyc();
        chk("bad_type done", 32'(done), 32'd0);

        for (int n = 0; n < 14; n++) run_vec(n, vecs[n]);

        // Reset in the middle of an INVTLB walk
        op_type = 3'd4; inv_op = 5'd0; op_valid = 1'b1;
        cyc();
        op_valid = 1'b0;
        for (int k = 1; k < 9; k++) cyc();
        chk("walk idx before reset", 32'(inv_rd_index), 32'd8);
        chk("walk busy before reset", 32'(busy), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst inv_rd_index", 32'(inv_rd_index), 32'd0);
        chk("midrst inv_clr", 32'(inv_clr), 32'd0);
        chk("midrst op_ready", 32'(op_ready), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        cyc();
        chk("after midrst op_ready", 32'(op_ready), 32'd1);
        chk("after midrst done", 32'(done), 32'd0);
        run_vec(100, vecs[0]);
        run_vec(101, vecs[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
